// File: rtl/serial_lsb_comparator.sv
// serial_lsb_comparator
//   Bit-serial unsigned magnitude comparator. Two WIDTH-bit operands are
//   captured on an accepted start. One bit pair per clock is then examined,
//   least significant bit first. Because a more significant differing bit
//   always overrides what the lower bits decided, the relation held after
//   the last bit is the true unsigned relation of a and b.
//
// Handshake (valid/ready style):
//   - The block is ready whenever busy=0, in IDLE or DONE. A start seen
//     high on a rising edge while ready is accepted, and a/b are captured
//     on that same edge.
//   - A start while busy=1 is ignored. Changes on a and b while busy=1 are
//     also ignored.
//   - done is the result-valid strobe. It is high for one cycle, WIDTH
//     edges after the accepting edge. g/e/s are held until the next done.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, overrides every other input
//   start     request a new comparison
//   a, b      WIDTH-bit unsigned operands
//   busy      comparison in progress
//   done      one-cycle pulse, result valid
//   g, e, s   a > b, a == b, a < b (registered, one-hot after first done)
//   state_dbg current FSM state (0=IDLE, 1=RUN, 2=DONE) for checkers
module serial_lsb_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             s,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  state_t           state;
  rel_t             rel;
  rel_t             next_rel;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] count;
  logic             last_bit;

  assign state_dbg = state;
  assign last_bit  = (count == CNT_W'(WIDTH - 1));

  // The current bit pair decides the relation only when the bits differ.
  // Otherwise the relation from the lower bits carries through.
  always_comb begin
    next_rel = rel;
    if (sa[0] && !sb[0]) begin
      next_rel = REL_GT;
    end else if (!sa[0] && sb[0]) begin
      next_rel = REL_LT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b0;
      s     <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      count <= '0;
      rel   <= REL_EQ;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Whether or not a new start arrives, done falls on this edge.
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            count <= '0;
            rel   <= REL_EQ;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rel   <= next_rel;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          count <= count + CNT_W'(1);
          if (last_bit) begin
            // Publish the relation including this final, most significant bit.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            g     <= (next_rel == REL_GT);
            e     <= (next_rel == REL_EQ);
            s     <= (next_rel == REL_LT);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_lsb_comparator.sv
module tb_serial_lsb_comparator;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic         start8 = 1'b0;
  logic [W-1:0] a8 = '0;
  logic [W-1:0] b8 = '0;
  logic         busy8, done8, g8, e8, s8;
  logic [1:0]   st8;

  // WIDTH=1 instance
  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         busy1, done1, g1, e1, s1;
  logic [1:0]   st1;

  serial_lsb_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .g(g8), .e(e8), .s(s8), .state_dbg(st8)
  );

  serial_lsb_comparator #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .g(g1), .e(e1), .s(s1), .state_dbg(st1)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected {g,e,s} per launched operation.
  logic [2:0] exp_q[$];

  // Reference model: plain unsigned comparison, returns {gt, eq, lt}.
  function automatic logic [2:0] model_rel(input logic [31:0] x, input logic [31:0] y);
    return {x > y, x == y, x < y};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse on the WIDTH=8 instance.
  task automatic drive_start8(input logic [W-1:0] av, input logic [W-1:0] bv);
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic drive_start1(input logic av, input logic bv);
    a1 = av;
    b1 = bv;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  // Counts edges until done is seen; n = -1 when the bound expires.
  task automatic wait_done8(output int n);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (done8 !== 1'b1) n = -1;
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (done1 !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (done1 !== 1'b1) n = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy8, done8, g8, e8, s8} !== 5'b0) begin
      errors++;
      $display("FAIL reset_w8: got busy/done/g/e/s=%b expected 00000", {busy8, done8, g8, e8, s8});
    end
    checks++;
    if ({busy1, done1, g1, e1, s1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_w1: got busy/done/g/e/s=%b expected 00000", {busy1, done1, g1, e1, s1});
    end
    rst = 1'b0;
    tick();
  endtask

  // Launches a single op, checks latency, result and one-cycle done.
  task automatic run_single(input string name, input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    logic [2:0] exp;
    exp_q.push_back(model_rel(32'(av), 32'(bv)));
    drive_start8(av, bv);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got busy=%b expected 1", name, busy8);
    end
    wait_done8(n);
    exp = exp_q.pop_front();
    checks++;
    if (n !== W) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges expected %0d", name, n, W);
    end
    checks++;
    if ({g8, e8, s8} !== exp) begin
      errors++;
      $display("FAIL %s_result: got g/e/s=%b expected %b (a=%h b=%h)", name, {g8, e8, s8}, exp, av, bv);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || {g8, e8, s8} !== exp) begin
      errors++;
      $display("FAIL %s_hold: got done=%b g/e/s=%b expected done=0 g/e/s=%b", name, done8, {g8, e8, s8}, exp);
    end
  endtask

  task automatic test_equal();
    run_single("equal_5a", 8'h5A, 8'h5A);
  endtask

  task automatic test_msb_override();
    run_single("msb_80_7f", 8'h80, 8'h7F);
  endtask

  task automatic test_back_to_back();
    int n;
    int extra;
    // Start held high: first op 00/FF, then FE/FF offered while busy.
    a8 = 8'h00;
    b8 = 8'hFF;
    start8 = 1'b1;
    tick();
    a8 = 8'hFE;
    wait_done8(n);
    checks++;
    if (n !== W || {g8, e8, s8} !== model_rel(32'h00, 32'hFF)) begin
      errors++;
      $display("FAIL b2b_first: got %0d edges g/e/s=%b expected %0d edges g/e/s=001", n, {g8, e8, s8}, W);
    end
    tick();
    wait_done8(n);
    start8 = 1'b0;
    checks++;
    if (n + 1 !== W + 1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between dones expected %0d", n + 1, W + 1);
    end
    checks++;
    if ({g8, e8, s8} !== model_rel(32'hFE, 32'hFF)) begin
      errors++;
      $display("FAIL b2b_second: got g/e/s=%b expected 001", {g8, e8, s8});
    end
    tick();
    // Toggle start while busy: exactly one done must follow.
    drive_start8(8'h00, 8'hFF);
    extra = 0;
    for (int i = 0; i < W; i++) begin
      start8 = (i % 2 == 0);
      a8 = W'($urandom);
      b8 = W'($urandom);
      if (done8 === 1'b1) extra++;
      tick();
    end
    start8 = 1'b0;
    checks++;
    if (done8 !== 1'b1 || extra !== 0 || s8 !== 1'b1) begin
      errors++;
      $display("FAIL toggle_busy: got done=%b early_dones=%0d s=%b expected done=1 early=0 s=1", done8, extra, s8);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8 === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL toggle_extra: got %0d extra done pulses expected 0", extra);
    end
  endtask

  task automatic test_mid_run_change();
    int n;
    logic [2:0] exp;
    exp = model_rel(32'h10, 32'h01);
    drive_start8(8'h10, 8'h01);
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin
      a8 = W'($urandom);
      b8 = W'($urandom);
      tick();
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || n !== W || {g8, e8, s8} !== exp) begin
      errors++;
      $display("FAIL mid_run_change: got done=%b after %0d edges g/e/s=%b expected done after %0d g/e/s=%b",
               done8, n, {g8, e8, s8}, W, exp);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    drive_start8(8'hFF, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy8, done8, g8, e8, s8} !== 5'b0) begin
      errors++;
      $display("FAIL abort_state: got busy/done/g/e/s=%b expected 00000", {busy8, done8, g8, e8, s8});
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", seen);
    end
    run_single("after_abort_3_5", 8'd3, 8'd5);
  endtask

  task automatic test_width1();
    int n;
    logic [2:0] exp;
    for (int k = 0; k < 4; k++) begin
      logic av;
      logic bv;
      av = k[1];
      bv = k[0];
      exp = model_rel(32'(av), 32'(bv));
      drive_start1(av, bv);
      wait_done1(n);
      checks++;
      if (n !== 1 || {g1, e1, s1} !== exp) begin
        errors++;
        $display("FAIL w1_case a=%b b=%b: got %0d edges g/e/s=%b expected 1 edge g/e/s=%b",
                 av, bv, n, {g1, e1, s1}, exp);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int n;
    int bad;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [2:0] exp;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom);
      bv = (i % 8 == 0) ? av : W'($urandom_range(0, 255));
      exp_q.push_back(model_rel(32'(av), 32'(bv)));
      drive_start8(av, bv);
      wait_done8(n);
      exp = exp_q.pop_front();
      checks++;
      if (n !== W || {g8, e8, s8} !== exp) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: a=%h b=%h got %0d edges g/e/s=%b expected %0d edges g/e/s=%b",
                   i, av, bv, n, {g8, e8, s8}, W, exp);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_equal();
    test_msb_override();
    test_back_to_back();
    test_mid_run_change();
    test_reset_abort();
    test_width1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
